// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side buffer.
package uart_pkg;
  localparam int UART_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } txf_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// Circular byte FIFO with registered full/empty/level flags and sticky overflow.
// UART_TXF_ALMOST_FULL_EN adds AF_LEVEL and a registered almost_full_o.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
`ifdef UART_TXF_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     wr_en_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
`ifdef UART_TXF_ALMOST_FULL_EN
  output logic                     almost_full_o,
`endif
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic             full_q, empty_q, overflow_q;
  logic             wr_ok, rd_ok;

  // Gating uses the flags as they stood at the start of the cycle, so a
  // same-edge pop never frees a slot for a write while full.
  assign wr_ok    = wr_en_i && !full_q;
  assign rd_ok    = rd_en_i && !empty_q;
  assign wr_ptr_d = wr_ok ? wr_ptr_q + LW'(1) : wr_ptr_q;
  assign rd_ptr_d = rd_ok ? rd_ptr_q + LW'(1) : rd_ptr_q;
  assign level_d  = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= (level_d == LW'(DEPTH));
      empty_q    <= (level_d == '0);
      overflow_q <= overflow_q | (wr_en_i & full_q);
    end
  end

`ifdef UART_TXF_ALMOST_FULL_EN
  logic almost_full_q;
  always_ff @(posedge clk) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= (level_d >= LW'(AF_LEVEL));
  end
  assign almost_full_o = almost_full_q;
`endif

  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus request sequencer feeding the UART core's transmit path.
// UART_TXF_ALMOST_FULL_EN adds parameter AF_LEVEL and output almost_full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WIDTH       = UART_WIDTH,
  parameter int ACK_TIMEOUT = 15
`ifdef UART_TXF_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL    = DEPTH - 2
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   ack_err,
`ifdef UART_TXF_ALMOST_FULL_EN
  output logic                   almost_full,
`endif
  input  logic                   tx_busy,
  output logic                   tx_req,
  output logic [WIDTH-1:0]       tx_data
);
  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  txf_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tx_req_q, tx_req_d, ack_err_q, ack_err_d, pop;
  logic [WIDTH-1:0] tx_data_q, tx_data_d, head;

  uart_sync_fifo #(
    .DEPTH(DEPTH), .WIDTH(WIDTH)
`ifdef UART_TXF_ALMOST_FULL_EN
    , .AF_LEVEL(AF_LEVEL)
`endif
  ) u_fifo (
    .clk(clk), .rst(rst),
    .wr_data_i(wr_data), .wr_en_i(wr_en),
    .rd_en_i(pop), .rd_data_o(head),
    .full_o(full), .empty_o(empty), .level_o(level),
`ifdef UART_TXF_ALMOST_FULL_EN
    .almost_full_o(almost_full),
`endif
    .overflow_o(overflow)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_req_d  = 1'b0;
    tx_data_d = tx_data_q;
    ack_err_d = ack_err_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: if (!empty && !tx_busy) begin
        pop       = 1'b1;
        tx_data_d = head;
        tx_req_d  = 1'b1;
        state_d   = S_REQ;
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_ACK;
      end
      // Timeout fires on the edge where the count would reach ACK_TIMEOUT-1,
      // i.e. ACK_TIMEOUT edges after tx_req rose.
      S_ACK: begin
        if (tx_busy) state_d = S_DONE;
        else if (cnt_q == CW'(ACK_TIMEOUT - 2)) begin
          ack_err_d = 1'b1;
          state_d   = S_IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_DONE: if (!tx_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign tx_req  = tx_req_q;
  assign tx_data = tx_data_q;
  assign ack_err = ack_err_q;
endmodule
